// File: rtl/mem_refill_arbiter.sv
// Shares one line-granular memory port between ICache refills and DCache MSHR traffic.
// One line transaction at a time: address phase, beat burst, then a one-cycle response.
module mem_refill_arbiter #(
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_req_valid_i,
  output logic                  ic_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
  input  logic                  ic_kill_i,
  output logic                  ic_rsp_valid_o,
  output logic [LINE_WIDTH-1:0] ic_rsp_data_o,
  input  logic                  dc_req_valid_i,
  output logic                  dc_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
  input  logic                  dc_req_we_i,
  input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
  input  logic [ID_WIDTH-1:0]   dc_req_id_i,
  output logic                  dc_rsp_valid_o,
  output logic                  dc_rsp_we_o,
  output logic [ID_WIDTH-1:0]   dc_rsp_id_o,
  output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic                  mem_req_we_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  output logic [BUS_WIDTH-1:0]  mem_wdata_o,
  output logic                  mem_wlast_o,
  input  logic                  mem_rvalid_i,
  input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
  input  logic                  mem_bvalid_i
);

  localparam int unsigned BEATS    = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFFSET_W) - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StRdata, StWdata, StWresp, StResp} state_e;

  state_e                state_q;
  logic                  owner_ic_q;
  logic                  we_q;
  logic                  ic_killed_q;
  logic                  last_ic_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [CNT_W-1:0]      cnt_q;

  logic last_beat;
  logic grant_ic;
  logic grant_dc;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  // Round-robin: on a tie, the requester not granted last time wins.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state_q == StIdle && !rst_i) begin
      if (ic_req_valid_i && (!dc_req_valid_i || !last_ic_q)) begin
        grant_ic = 1'b1;
      end else if (dc_req_valid_i) begin
        grant_dc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ic_killed_q <= 1'b0;
      last_ic_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_ic || grant_dc) begin
            owner_ic_q <= grant_ic;
            last_ic_q  <= grant_ic;
            addr_q     <= (grant_ic ? ic_req_addr_i : dc_req_addr_i) & ~OFF_MASK;
            we_q       <= grant_dc & dc_req_we_i;
            id_q       <= dc_req_id_i;
            line_q     <= dc_req_wdata_i;
            cnt_q      <= '0;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          if (mem_req_ready_i) state_q <= we_q ? StWdata : StRdata;
        end
        StRdata: begin
          if (mem_rvalid_i) begin
            line_q[cnt_q*BUS_WIDTH +: BUS_WIDTH] <= mem_rdata_i;
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= StResp;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StWdata: begin
          if (mem_wready_i) begin
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= StWresp;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StWresp: begin
          if (mem_bvalid_i) state_q <= StResp;
        end
        StResp: begin
          ic_killed_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // A kill during the RESP cycle itself is applied combinationally on the pulse.
      if (state_q != StIdle && state_q != StResp && owner_ic_q && ic_kill_i) begin
        ic_killed_q <= 1'b1;
      end
    end
  end

  assign ic_req_ready_o  = grant_ic;
  assign dc_req_ready_o  = grant_dc;

  assign mem_req_valid_o = (state_q == StAddr);
  assign mem_req_addr_o  = addr_q;
  assign mem_req_we_o    = we_q;
  assign mem_wvalid_o    = (state_q == StWdata);
  assign mem_wdata_o     = line_q[cnt_q*BUS_WIDTH +: BUS_WIDTH];
  assign mem_wlast_o     = (state_q == StWdata) && last_beat;

  assign ic_rsp_valid_o  = (state_q == StResp) && owner_ic_q && !ic_killed_q && !ic_kill_i;
  assign ic_rsp_data_o   = line_q;
  assign dc_rsp_valid_o  = (state_q == StResp) && !owner_ic_q;
  assign dc_rsp_we_o     = we_q;
  assign dc_rsp_id_o     = id_q;
  assign dc_rsp_data_o   = line_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: transaction-level model checked every cycle at negedge,
// directed scenarios with literal expectations, then a randomized soak.
module tb_mem_refill_arbiter;

  localparam int unsigned LW    = 512;
  localparam int unsigned BW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 2;
  localparam int unsigned BEATS = LW / BW;
  localparam logic [AW-1:0] OFF_MASK = AW'(LW / 8 - 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          ic_req_valid_i, ic_req_ready_o, ic_kill_i, ic_rsp_valid_o;
  logic [AW-1:0] ic_req_addr_i;
  logic [LW-1:0] ic_rsp_data_o;
  logic          dc_req_valid_i, dc_req_ready_o, dc_req_we_i, dc_rsp_valid_o, dc_rsp_we_o;
  logic [AW-1:0] dc_req_addr_i;
  logic [LW-1:0] dc_req_wdata_i, dc_rsp_data_o;
  logic [IW-1:0] dc_req_id_i, dc_rsp_id_o;
  logic          mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_wvalid_o, mem_wready_i, mem_wlast_o, mem_rvalid_i, mem_bvalid_i;
  logic [BW-1:0] mem_wdata_o, mem_rdata_i;

  mem_refill_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ic_req_valid_i (ic_req_valid_i),
    .ic_req_ready_o (ic_req_ready_o),
    .ic_req_addr_i  (ic_req_addr_i),
    .ic_kill_i      (ic_kill_i),
    .ic_rsp_valid_o (ic_rsp_valid_o),
    .ic_rsp_data_o  (ic_rsp_data_o),
    .dc_req_valid_i (dc_req_valid_i),
    .dc_req_ready_o (dc_req_ready_o),
    .dc_req_addr_i  (dc_req_addr_i),
    .dc_req_we_i    (dc_req_we_i),
    .dc_req_wdata_i (dc_req_wdata_i),
    .dc_req_id_i    (dc_req_id_i),
    .dc_rsp_valid_o (dc_rsp_valid_o),
    .dc_rsp_we_o    (dc_rsp_we_o),
    .dc_rsp_id_o    (dc_rsp_id_o),
    .dc_rsp_data_o  (dc_rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_we_o   (mem_req_we_o),
    .mem_wvalid_o   (mem_wvalid_o),
    .mem_wready_i   (mem_wready_i),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wlast_o    (mem_wlast_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_bvalid_i   (mem_bvalid_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model of the one in-flight transaction
  bit            busy, addr_done, bdone, last_ic, t_ic, t_we, t_killed;
  logic [AW-1:0] t_addr;
  logic [IW-1:0] t_id;
  logic [LW-1:0] t_line;
  int            beats;

  // Event log for the directed scenarios
  int            grants[$];
  int            acc_q[$];
  int            n_done, n_ic_rsp, n_wbeats, n_wlast, n_rbeats, acc_cyc, rsp_cyc;
  logic [LW-1:0] ic_rsp_cap;
  logic          dc_we_cap;
  logic [IW-1:0] dc_id_cap;
  logic [AW-1:0] addr_cap;
  bit            ic_acc, dc_acc;

  // Stimulus knobs
  int mode = 0;  // 0: ideal memory, 1: random
  bit toggle_w, auto_ic, auto_dc, rst_hold, rst_fired;
  int kill_beat = -1;
  int rst_beat = -1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_cycle();
    bit g_ic, g_dc, wv, in_resp, exp_ic_v;
    ic_acc = 0;
    dc_acc = 0;
    if (rst_i) begin
      busy = 0;
      last_ic = 0;
      return;
    end
    g_ic = 0;
    g_dc = 0;
    if (!busy) begin
      g_ic = ic_req_valid_i && (!dc_req_valid_i || !last_ic);
      g_dc = dc_req_valid_i && !g_ic;
    end
    chk("ic_ready", LW'(ic_req_ready_o), LW'(g_ic));
    chk("dc_ready", LW'(dc_req_ready_o), LW'(g_dc));
    chk("mem_req_valid", LW'(mem_req_valid_o), LW'(busy && !addr_done));
    if (busy && !addr_done) begin
      chk("mem_req_addr", LW'(mem_req_addr_o), LW'(t_addr));
      chk("mem_req_we", LW'(mem_req_we_o), LW'(t_we));
    end
    wv = busy && addr_done && t_we && beats < BEATS;
    chk("mem_wvalid", LW'(mem_wvalid_o), LW'(wv));
    chk("mem_wlast", LW'(mem_wlast_o), LW'(wv && beats == BEATS - 1));
    if (wv) chk("mem_wdata", LW'(mem_wdata_o), LW'(t_line[beats*BW +: BW]));
    in_resp  = busy && addr_done && beats == BEATS && (!t_we || bdone);
    exp_ic_v = in_resp && t_ic && !t_killed && !ic_kill_i;
    chk("ic_rsp_valid", LW'(ic_rsp_valid_o), LW'(exp_ic_v));
    chk("dc_rsp_valid", LW'(dc_rsp_valid_o), LW'(in_resp && !t_ic));
    if (exp_ic_v) chk("ic_rsp_data", ic_rsp_data_o, t_line);
    if (in_resp && !t_ic) begin
      chk("dc_rsp_we", LW'(dc_rsp_we_o), LW'(t_we));
      chk("dc_rsp_id", LW'(dc_rsp_id_o), LW'(t_id));
      if (!t_we) chk("dc_rsp_data", dc_rsp_data_o, t_line);
    end

    if (ic_rsp_valid_o) begin n_ic_rsp++; ic_rsp_cap = ic_rsp_data_o; rsp_cyc = cyc; end
    if (dc_rsp_valid_o) begin dc_we_cap = dc_rsp_we_o; dc_id_cap = dc_rsp_id_o; end
    if (mem_req_valid_o && mem_req_ready_i) addr_cap = mem_req_addr_o;
    if (mem_wvalid_o && mem_wready_i) begin n_wbeats++; if (mem_wlast_o) n_wlast++; end

    if (in_resp) begin
      busy = 0;
      n_done++;
    end else if (busy) begin
      if (t_ic && ic_kill_i) t_killed = 1;
      if (!addr_done) begin
        addr_done = mem_req_ready_i;
      end else if (beats < BEATS) begin
        if (!t_we && mem_rvalid_i) begin
          t_line[beats*BW +: BW] = mem_rdata_i;
          beats++;
          n_rbeats++;
        end else if (t_we && mem_wready_i) begin
          beats++;
        end
      end else if (t_we && !bdone) begin
        bdone = mem_bvalid_i;
      end
    end else if (g_ic || g_dc) begin
      busy = 1; addr_done = 0; beats = 0; bdone = 0; t_killed = 0;
      t_ic = g_ic;
      last_ic = g_ic;
      t_addr = (g_ic ? ic_req_addr_i : dc_req_addr_i) & ~OFF_MASK;
      t_we = g_dc && dc_req_we_i;
      t_id = dc_req_id_i;
      t_line = dc_req_wdata_i;
      grants.push_back(g_ic ? 0 : 1);
      acc_q.push_back(cyc);
      acc_cyc = cyc;
      ic_acc = g_ic;
      dc_acc = g_dc;
    end
  endtask

  task automatic new_ic(input logic [AW-1:0] a);
    ic_req_valid_i = 1;
    ic_req_addr_i  = a;
  endtask

  task automatic new_dc(input logic [AW-1:0] a, input logic we, input logic [IW-1:0] id);
    dc_req_valid_i = 1;
    dc_req_addr_i  = a;
    dc_req_we_i    = we;
    dc_req_id_i    = id;
    dc_req_wdata_i = rand_line();
  endtask

  task automatic drive();
    cyc++;
    if (ic_acc) begin if (auto_ic) new_ic($urandom); else ic_req_valid_i = 0; end
    if (dc_acc) begin
      if (auto_dc) new_dc($urandom, 1'($urandom), IW'($urandom)); else dc_req_valid_i = 0;
    end
    rst_i = rst_hold;
    if (mode == 0) begin
      mem_req_ready_i = 1;
      mem_wready_i    = toggle_w ? cyc[0] : 1'b1;
      mem_rvalid_i    = 1;
      mem_rdata_i     = BW'(beats);
      mem_bvalid_i    = 1;
      ic_kill_i = (kill_beat >= 0) && busy && t_ic && addr_done && beats == kill_beat;
      if (rst_beat >= 0 && busy && !t_we && addr_done && beats == rst_beat) begin
        rst_i = 1;
        rst_beat = -1;
        rst_fired = 1;
      end
    end else begin
      mem_req_ready_i = 1'($urandom);
      mem_wready_i    = 1'($urandom);
      mem_rvalid_i    = 1'($urandom);
      mem_rdata_i     = {$urandom, $urandom};
      mem_bvalid_i    = ($urandom % 4) == 0;
      ic_kill_i       = ($urandom % 16) == 0;
      if (!ic_req_valid_i && ($urandom % 4) == 0) new_ic($urandom);
      if (!dc_req_valid_i && ($urandom % 4) == 0) new_dc($urandom, 1'($urandom), IW'($urandom));
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      step();
      n++;
    end
    if (n_done < target) chk("timeout", LW'(n_done), LW'(target));
  endtask

  task automatic do_reset();
    ic_req_valid_i = 0;
    dc_req_valid_i = 0;
    rst_hold = 1;
    rst_i = 1;
    step();
    rst_hold = 0;
    rst_i = 0;
  endtask

  initial begin
    int g0, d0, w0, l0, r0, i0, n;
    rst_i = 1; rst_hold = 1;
    ic_req_valid_i = 0; ic_req_addr_i = '0; ic_kill_i = 0;
    dc_req_valid_i = 0; dc_req_addr_i = '0; dc_req_we_i = 0; dc_req_wdata_i = '0;
    dc_req_id_i = '0;
    mem_req_ready_i = 0; mem_wready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    mem_bvalid_i = 0;
    repeat (2) step();
    rst_hold = 0;
    rst_i = 0;
    step();
    chk("rst_memv", LW'(mem_req_valid_o), '0);
    chk("rst_wvalid", LW'(mem_wvalid_o), '0);
    chk("rst_icrsp", LW'(ic_rsp_valid_o), '0);
    chk("rst_dcrsp", LW'(dc_rsp_valid_o), '0);

    // Lone ICache read, ideal memory, beat k carries value k
    d0 = n_done;
    new_ic(32'h8000_0024);
    wait_done(d0 + 1, 50);
    chk("t1_latency", LW'(rsp_cyc - acc_cyc), LW'(10));
    chk("t1_addr", LW'(addr_cap), LW'(32'h8000_0000));
    for (int k = 0; k < BEATS; k++) chk("t1_word", LW'(ic_rsp_cap[k*BW +: BW]), LW'(k));

    // Tie after reset goes to ICache, then DCache refill id=2
    do_reset();
    g0 = grants.size();
    d0 = n_done;
    new_ic(32'h0000_1240);
    new_dc(32'h0000_2280, 1'b0, 2'd2);
    wait_done(d0 + 2, 80);
    chk("t2_first", LW'(grants[g0]), LW'(0));
    chk("t2_second", LW'(grants[g0+1]), LW'(1));
    chk("t2_id", LW'(dc_id_cap), LW'(2));
    chk("t2_we", LW'(dc_we_cap), LW'(0));

    // DCache writeback with toggling wready
    toggle_w = 1;
    d0 = n_done; w0 = n_wbeats; l0 = n_wlast;
    new_dc(32'h8000_1000, 1'b1, 2'd1);
    wait_done(d0 + 1, 80);
    toggle_w = 0;
    chk("t3_beats", LW'(n_wbeats - w0), LW'(8));
    chk("t3_wlast", LW'(n_wlast - l0), LW'(1));
    chk("t3_we", LW'(dc_we_cap), LW'(1));
    chk("t3_addr", LW'(addr_cap), LW'(32'h8000_1000));

    // Kill during read beat 3, then a normal ICache read
    kill_beat = 3;
    d0 = n_done; i0 = n_ic_rsp; r0 = n_rbeats;
    new_ic(32'h0000_4000);
    wait_done(d0 + 1, 50);
    kill_beat = -1;
    chk("t4_suppressed", LW'(n_ic_rsp - i0), LW'(0));
    chk("t4_rbeats", LW'(n_rbeats - r0), LW'(8));
    new_ic(32'h0000_4040);
    wait_done(d0 + 2, 50);
    chk("t4_next", LW'(n_ic_rsp - i0), LW'(1));

    // Continuous dual requests alternate
    do_reset();
    g0 = grants.size();
    d0 = n_done;
    auto_ic = 1;
    auto_dc = 1;
    new_ic(32'h0001_0000);
    new_dc(32'h0002_0000, 1'b0, 2'd3);
    wait_done(d0 + 4, 200);
    auto_ic = 0;
    auto_dc = 0;
    ic_req_valid_i = 0;
    dc_req_valid_i = 0;
    for (int k = 0; k < 4; k++) chk("t5_grant", LW'(grants[g0+k]), LW'(k % 2));
    chk("t5_spacing", LW'(acc_q[g0+1] - acc_q[g0]), LW'(11));

    // Reset at read beat 5, then a fresh read starts at beat 0
    rst_fired = 0;
    rst_beat = 5;
    new_ic(32'h0000_8000);
    n = 0;
    while (!rst_fired && n < 50) begin step(); n++; end
    chk("t6_fired", LW'(rst_fired), LW'(1));
    step();
    chk("t6_memv", LW'(mem_req_valid_o), '0);
    chk("t6_wvalid", LW'(mem_wvalid_o), '0);
    chk("t6_icrsp", LW'(ic_rsp_valid_o), '0);
    chk("t6_dcrsp", LW'(dc_rsp_valid_o), '0);
    chk("t6_icrdy", LW'(ic_req_ready_o), '0);
    step();
    d0 = n_done; i0 = n_ic_rsp;
    new_ic(32'h0000_8040);
    wait_done(d0 + 1, 50);
    chk("t6_rsp", LW'(n_ic_rsp - i0), LW'(1));
    for (int k = 0; k < BEATS; k++) chk("t6_word", LW'(ic_rsp_cap[k*BW +: BW]), LW'(k));

    // Randomized soak, then drain with ideal memory
    do_reset();
    mode = 1;
    repeat (4000) step();
    mode = 0;
    n = 0;
    while ((busy || ic_req_valid_i || dc_req_valid_i) && n < 300) begin step(); n++; end
    chk("drain", LW'(busy || ic_req_valid_i || dc_req_valid_i), '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
